// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and request payload for alu_arbiter.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_NOTA = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRA1 = 4'b1000;
  localparam logic [OP_W-1:0] OP_SLL1 = 4'b1001;
  localparam logic [OP_W-1:0] OP_SRL1 = 4'b1010;
  localparam logic [OP_W-1:0] OP_ROL1 = 4'b1100;
  localparam logic [OP_W-1:0] OP_ROR1 = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational shared ALU; unknown opcodes yield zero (legality is judged by the caller).
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_op,
  output logic [DATA_W-1:0] o_res_c,
  output logic              o_zero_c
);

  always_comb begin
    o_res_c = '0;
    case (i_op)
      OP_ADD:  o_res_c = i_a + i_b;
      OP_SUB:  o_res_c = i_a - i_b;
      OP_AND:  o_res_c = i_a & i_b;
      OP_OR:   o_res_c = i_a | i_b;
      OP_NOTA: o_res_c = ~i_a;
      OP_SRA1: o_res_c = DATA_W'($signed(i_a) >>> 1);
      OP_SLL1: o_res_c = {i_a[DATA_W-2:0], 1'b0};
      OP_SRL1: o_res_c = {1'b0, i_a[DATA_W-1:1]};
      OP_ROL1: o_res_c = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
      OP_ROR1: o_res_c = {i_a[0], i_a[DATA_W-1:1]};
      default: o_res_c = '0;
    endcase
  end

  assign o_zero_c = (o_res_c == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU, one transaction in flight.
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin grant; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
)(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req0_Valid,
  output logic              Req0_Ready,
  input  logic [DATA_W-1:0] Req0_A,
  input  logic [DATA_W-1:0] Req0_B,
  input  logic [OP_W-1:0]   Req0_Op,
  input  logic              Req1_Valid,
  output logic              Req1_Ready,
  input  logic [DATA_W-1:0] Req1_A,
  input  logic [DATA_W-1:0] Req1_B,
  input  logic [OP_W-1:0]   Req1_Op,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [DATA_W-1:0] Rsp_Out,
  output logic              Rsp_Zero,
  output logic              Rsp_Id,
  output logic              Rsp_Err
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  alu_req_t          r_req;
  alu_req_t          w_req_in;
  logic              r_id;
  logic              w_grant1;
  logic              w_accept;
  logic              w_last_exec;
  logic              w_rsp_done;
  logic              w_op_legal;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_zero;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  // Last granted requester; reset to 1 so requester 0 wins the first contest.
  logic r_last;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant1;
    end
  end

  assign w_grant1 = (Req0_Valid && Req1_Valid) ? ~r_last : ~Req0_Valid;
`else
  assign w_grant1 = ~Req0_Valid;
`endif

  assign w_req_in = w_grant1 ? '{a: Req1_A, b: Req1_B, op: Req1_Op}
                             : '{a: Req0_A, b: Req0_B, op: Req0_Op};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready is combinational and held low while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    Req0_Ready  = 1'b0;
    Req1_Ready  = 1'b0;
    w_accept    = 1'b0;
    w_last_exec = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        Req0_Ready = Rst_n & Req0_Valid & ~w_grant1;
        Req1_Ready = Rst_n & Req1_Valid & w_grant1;
        w_accept   = Rst_n & ((Req0_Valid & ~w_grant1) | (Req1_Valid & w_grant1));
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_cnt == '0) begin
          w_last_exec = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (Rsp_Ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_op_legal = 1'b0;
    case (r_req.op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOTA,
      OP_SRA1, OP_SLL1, OP_SRL1, OP_ROL1, OP_ROR1: w_op_legal = 1'b1;
      default: w_op_legal = 1'b0;
    endcase
  end

  alu u_alu (
    .i_a      (r_req.a),
    .i_b      (r_req.b),
    .i_op     (r_req.op),
    .o_res_c  (w_alu_res),
    .o_zero_c (w_alu_zero)
  );

  // Capture on handshake, count down through EXEC, register the result into RESP.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt     <= '0;
      r_req     <= '0;
      r_id      <= 1'b0;
      Rsp_Valid <= 1'b0;
      Rsp_Out   <= '0;
      Rsp_Zero  <= 1'b0;
      Rsp_Id    <= 1'b0;
      Rsp_Err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req <= w_req_in;
        r_id  <= w_grant1;
        r_cnt <= CNT_W'(EXEC_CYCLES - 1);
      end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_last_exec) begin
        Rsp_Valid <= 1'b1;
        Rsp_Out   <= w_op_legal ? w_alu_res : '0;
        Rsp_Zero  <= w_op_legal ? w_alu_zero : 1'b1;
        Rsp_Err   <= ~w_op_legal;
        Rsp_Id    <= r_id;
      end else if (w_rsp_done) begin
        Rsp_Valid <= 1'b0;
      end
    end
  end

endmodule
